// File: rtl/counter_decoder.sv
// counter_decoder
//   Decodes the 5-bit state code of an up/down 5-state code counter into a
//   position 0..4, tracks count direction, and flags illegal codes and
//   skipped steps. A saturating error counter accumulates both fault kinds.
//
// Ports
//   clk        : clock, all state updates on rising edge
//   rst        : synchronous active-high reset
//   code_in    : 5-bit state code from the counter
//   sample     : code_in is evaluated only on edges where sample=1
//   err_clr    : clears err_count (a same-edge counted error leaves it at 1)
//   index      : decoded position 0..4 (registered)
//   dir        : last observed direction, 0=up 1=down (registered)
//   locked     : high while tracking a reference code
//   illegal    : one-cycle pulse on an unknown sampled code
//   step_err   : one-cycle pulse on a legal but non-adjacent sampled code
//   err_count  : saturating count of illegal plus step errors
module counter_decoder #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       code_in,
    input  logic             sample,
    input  logic             err_clr,
    output logic [2:0]       index,
    output logic             dir,
    output logic             locked,
    output logic             illegal,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       index_q, index_d;
    logic             dir_q, dir_d;
    logic             illegal_q, illegal_d;
    logic             step_err_q, step_err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic             code_legal;
    logic [2:0]       code_pos;
    logic [3:0]       fwd_sum;
    logic [3:0]       fwd_dist;
    logic             err_inc;

    // Returns {legal, position}.
    function automatic logic [3:0] decode_code(input logic [4:0] c);
        case (c)
            5'b00001: decode_code = {1'b1, 3'd0};
            5'b01000: decode_code = {1'b1, 3'd1};
            5'b00011: decode_code = {1'b1, 3'd2};
            5'b10101: decode_code = {1'b1, 3'd3};
            5'b10000: decode_code = {1'b1, 3'd4};
            default:  decode_code = {1'b0, 3'd0};
        endcase
    endfunction

    always_comb begin
        {code_legal, code_pos} = decode_code(code_in);
        // Forward distance (code_pos - index) mod 5, both operands in 0..4.
        fwd_sum  = {1'b0, code_pos} + 4'd5 - {1'b0, index_q};
        fwd_dist = (fwd_sum >= 4'd5) ? (fwd_sum - 4'd5) : fwd_sum;
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        dir_d      = dir_q;
        illegal_d  = 1'b0;
        step_err_d = 1'b0;
        err_inc    = 1'b0;

        if (sample) begin
            if (!code_legal) begin
                illegal_d = 1'b1;
                err_inc   = 1'b1;
                state_d   = FAULT;
            end else if (state_q != TRACK) begin
                index_d = code_pos;
                state_d = TRACK;
            end else begin
                case (fwd_dist)
                    4'd0: ;
                    4'd1: begin
                        index_d = code_pos;
                        dir_d   = 1'b0;
                    end
                    4'd4: begin
                        index_d = code_pos;
                        dir_d   = 1'b1;
                    end
                    default: begin
                        // Distance 2 or 3: a step was missed, reacquire.
                        step_err_d = 1'b1;
                        err_inc    = 1'b1;
                        index_d    = code_pos;
                        state_d    = ACQ;
                    end
                endcase
            end
        end

        // Clear wins over accumulation, but an error on the same edge counts.
        if (err_clr) begin
            err_count_d = err_inc ? {{(ERR_W-1){1'b0}}, 1'b1} : '0;
        end else if (err_inc && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACQ;
            index_q     <= 3'd0;
            dir_q       <= 1'b0;
            illegal_q   <= 1'b0;
            step_err_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            dir_q       <= dir_d;
            illegal_q   <= illegal_d;
            step_err_q  <= step_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign index     = index_q;
    assign dir       = dir_q;
    assign locked    = (state_q == TRACK);
    assign illegal   = illegal_q;
    assign step_err  = step_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_counter_decoder.sv
module tb_counter_decoder;

    localparam int ERR_W = 8;
    localparam int CMAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       code_in;
    logic             sample;
    logic             err_clr;
    logic [2:0]       index;
    logic             dir;
    logic             locked;
    logic             illegal;
    logic             step_err;
    logic [ERR_W-1:0] err_count;

    counter_decoder #(.ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .code_in   (code_in),
        .sample    (sample),
        .err_clr   (err_clr),
        .index     (index),
        .dir       (dir),
        .locked    (locked),
        .illegal   (illegal),
        .step_err  (step_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int dr;
        int lk;
        int ill;
        int se;
        int cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: 0=ACQ 1=TRACK 2=FAULT
    int m_state = 0;
    int m_idx   = 0;
    int m_dir   = 0;
    int m_cnt   = 0;
    int m_ill   = 0;
    int m_se    = 0;

    logic [4:0] code_tab [5] = '{5'b00001, 5'b01000, 5'b00011, 5'b10101, 5'b10000};

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int find_pos(input logic [4:0] c);
        int p;
        p = -1;
        for (int k = 0; k < 5; k++) if (code_tab[k] == c) p = k;
        return p;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic [4:0] c, input logic clr);
        int p;
        int inc;
        exp_t e;
        if (r) begin
            m_state = 0; m_idx = 0; m_dir = 0; m_cnt = 0; m_ill = 0; m_se = 0;
        end else begin
            m_ill = 0; m_se = 0; inc = 0;
            if (s) begin
                p = find_pos(c);
                if (p < 0) begin
                    m_ill = 1; inc = 1; m_state = 2;
                end else if (m_state != 1) begin
                    m_idx = p; m_state = 1;
                end else if (p == (m_idx + 1) % 5) begin
                    m_idx = p; m_dir = 0;
                end else if (p == (m_idx + 4) % 5) begin
                    m_idx = p; m_dir = 1;
                end else if (p != m_idx) begin
                    m_se = 1; inc = 1; m_idx = p; m_state = 0;
                end
            end
            if (clr) m_cnt = inc;
            else if (inc != 0 && m_cnt < CMAX) m_cnt++;
        end
        e.idx = m_idx; e.dr = m_dir; e.lk = (m_state == 1) ? 1 : 0;
        e.ill = m_ill; e.se = m_se; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic [4:0] c, input logic clr);
        exp_t e;
        rst = r; sample = s; code_in = c; err_clr = clr;
        model_step(r, s, c, clr);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_val("index",     int'(index),     e.idx);
            check_val("dir",       int'(dir),       e.dr);
            check_val("locked",    int'(locked),    e.lk);
            check_val("illegal",   int'(illegal),   e.ill);
            check_val("step_err",  int'(step_err),  e.se);
            check_val("err_count", int'(err_count), e.cnt);
            check_val("one_hot_err", int'(illegal & step_err), 0);
        end
    endtask

    task automatic samp(input logic [4:0] c);
        step(1'b0, 1'b1, c, 1'b0);
    endtask

    initial begin
        rst = 1'b1; sample = 1'b0; code_in = 5'd0; err_clr = 1'b0;
        @(posedge clk); #1;

        // Reset state
        step(1'b1, 1'b0, 5'd0, 1'b0);

        // Up count with wrap 4->0
        samp(5'b00001); samp(5'b01000); samp(5'b00011);
        samp(5'b10101); samp(5'b10000); samp(5'b00001);
        // Hold with sample=0 while code changes, then stall on same code
        step(1'b0, 1'b0, 5'b11111, 1'b0);
        samp(5'b00001);

        // Down count with wrap 0->4
        step(1'b1, 1'b0, 5'd0, 1'b0);
        samp(5'b00001); samp(5'b10000); samp(5'b10101);

        // Illegal code in TRACK at index 2
        step(1'b1, 1'b0, 5'd0, 1'b0);
        samp(5'b00001); samp(5'b01000); samp(5'b00011);
        samp(5'b11111); samp(5'b10101);

        // Skip error
        step(1'b1, 1'b0, 5'd0, 1'b0);
        samp(5'b00001); samp(5'b00011); samp(5'b10101);
        // Skip backwards by distance 3 from TRACK
        samp(5'b01000);

        // Saturation and clear
        step(1'b1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 260; i++) samp(5'b11111);
        step(1'b0, 1'b1, 5'b11111, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b1);
        // Saturate again, clear alone while saturated
        for (int i = 0; i < 256; i++) samp(5'b00000);
        step(1'b0, 1'b0, 5'd0, 1'b1);

        // Reset priority mid-TRACK with err_count=5
        step(1'b1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) samp(5'b10110);
        samp(5'b00001);
        step(1'b1, 1'b1, 5'b01000, 1'b1);
        samp(5'b00011);

        // Random mix of codes, samples and clears
        for (int i = 0; i < 300; i++) begin
            logic [4:0] c;
            c = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                             : code_tab[$urandom_range(0, 4)];
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), c,
                 ($urandom_range(0, 15) == 0));
        end

        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
